datapath_mem_responder: RTL and testbench

//  Responder (cache side) of the datapath<->cache request interface.
//  - Accepts instruction fetch and data load/store requests from the pipelined datapath.
//  - Serialises them onto one single-ported backing RAM and returns one-cycle ihit/dhit pulses with load data.
//  - Latches halt and then refuses further traffic.
//  - Sits between the datapath and the RAM in place of a real cache.

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/datapath_mem_responder_if.sv | 42 ++++
 rtl/access_timer.sv | 29 ++
 rtl/datapath_mem_responder.sv | 119 +++++++++++
 tb/tb_datapath_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the datapath<->memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    DACC,
    IACC,
    RESP,
    HALTED
  } memrsp_state_t;

  typedef enum logic [1:0] {
    OP_IREAD,
    OP_DREAD,
    OP_DWRITE
  } memrsp_op_t;

  localparam int    MEMRSP_TIMEOUT  = 16;
  localparam word_t MEMRSP_BAD_WORD = 32'hBAD1BAD1;

  // The RAM is word organised; byte offset bits never reach it.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/datapath_mem_responder_if.sv
// Datapath request/response bundle plus the backing-RAM port.
// Latency: n/a (wires only).
// Backpressure: requests are levels held until the matching hit pulse.
interface datapath_mem_responder_if;

  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        halted;
  logic        timeout_err;

  // Datapath + RAM side (drives requests and RAM responses).
  modport master (
    output halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ram_load, ram_ready,
    input  ihit, dhit, imemload, dmemload, ram_ren, ram_wen, ram_addr, ram_store,
    input  halted, timeout_err
  );

  // Responder side.
  modport slave (
    input  halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ram_load, ram_ready,
    output ihit, dhit, imemload, dmemload, ram_ren, ram_wen, ram_addr, ram_store,
    output halted, timeout_err
  );

endinterface

// File: rtl/access_timer.sv
// Per-access cycle counter; expired flags the last permitted cycle (TIMEOUT-1).
// Latency: count visible the cycle after enable; expired is combinational on count.
// Backpressure: none; holds at the expiry value until cleared.
module access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  // Count access cycles; cleared whenever no access is in flight.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/datapath_mem_responder.sv
// Serialises fetch/load/store requests onto one RAM port, returns one-cycle ihit/dhit.
// Latency: request sampled in IDLE, RAM enables next cycle, hit the cycle after ram_ready.
// Backpressure: requests wait while busy; aborts after TIMEOUT cycles; halt blocks all traffic.
module datapath_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT  = MEMRSP_TIMEOUT,
  parameter word_t BAD_WORD = MEMRSP_BAD_WORD
) (
  input logic                    CLK,
  input logic                    RST,
  datapath_mem_responder_if.slave bus
);

  memrsp_state_t state, state_nxt;
  memrsp_op_t    acc_op, new_op;
  word_t         acc_addr, acc_store;
  word_t         imemload_q, dmemload_q;
  logic          terr_q;
  logic          start_acc;
  logic          in_acc;
  logic          expired;

  assign in_acc = (state == DACC) || (state == IACC);

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .clr     (!in_acc),
    .en      (in_acc),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: data beats fetch; RESP never samples new requests.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    new_op    = OP_IREAD;
    case (state)
      IDLE: begin
        if (bus.halt) begin
          state_nxt = HALTED;
        end else if (bus.dmemWEN || bus.dmemREN) begin
          state_nxt = DACC;
          start_acc = 1'b1;
          new_op    = bus.dmemWEN ? OP_DWRITE : OP_DREAD;
        end else if (bus.imemREN) begin
          state_nxt = IACC;
          start_acc = 1'b1;
          new_op    = OP_IREAD;
        end
      end
      DACC, IACC: begin
        if (bus.ram_ready || expired) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = bus.halt ? HALTED : IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, load registers and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_op     <= OP_IREAD;
      acc_addr   <= '0;
      acc_store  <= '0;
      imemload_q <= '0;
      dmemload_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      if (start_acc) begin
        acc_op    <= new_op;
        acc_addr  <= word_align((new_op == OP_IREAD) ? bus.imemaddr : bus.dmemaddr);
        acc_store <= bus.dmemstore;
      end
      if (in_acc) begin
        if (bus.ram_ready) begin
          if (acc_op == OP_IREAD) begin
            imemload_q <= bus.ram_load;
          end else if (acc_op == OP_DREAD) begin
            dmemload_q <= bus.ram_load;
          end
        end else if (expired) begin
          // A timed-out store has no load value to return.
          if (acc_op == OP_IREAD) begin
            imemload_q <= BAD_WORD;
          end else if (acc_op == OP_DREAD) begin
            dmemload_q <= BAD_WORD;
          end
          terr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ram_ren     = in_acc && (acc_op != OP_DWRITE);
  assign bus.ram_wen     = in_acc && (acc_op == OP_DWRITE);
  assign bus.ram_addr    = in_acc ? acc_addr  : '0;
  assign bus.ram_store   = in_acc ? acc_store : '0;
  assign bus.ihit        = (state == RESP) && (acc_op == OP_IREAD);
  assign bus.dhit        = (state == RESP) && (acc_op != OP_IREAD);
  assign bus.imemload    = imemload_q;
  assign bus.dmemload    = dmemload_q;
  assign bus.halted      = (state == HALTED);
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_datapath_mem_responder.sv
// Self-checking bench: vector table, hand sequences and randomized accesses vs a reference model.
// Latency: n/a.
// Backpressure: RAM model answers after a programmable number of enabled cycles.
module tb_datapath_mem_responder;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

  logic clk = 1'b0;
  logic rst;

  datapath_mem_responder_if bus();

  datapath_mem_responder #(.TIMEOUT(TIMEOUT), .BAD_WORD(BAD_WORD)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // RAM model (environment) and reference state (expected DUT behaviour).
  int          ram_delay = 0;
  int          acc_cnt   = 0;
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_iload = 32'h0;
  logic [31:0] ref_dload = 32'h0;
  logic        ref_terr  = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // RAM answers ram_delay cycles after its enables first go high.
  always @(negedge clk) begin
    if (bus.ram_ren || bus.ram_wen) begin
      if (acc_cnt == ram_delay) begin
        if (bus.ram_wen) ram_mem[bus.ram_addr] = bus.ram_store;
        bus.ram_load  = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : init_word(bus.ram_addr);
        bus.ram_ready = 1'b1;
      end else begin
        bus.ram_load  = 32'hFFFF_FFFF;
        bus.ram_ready = 1'b0;
      end
      acc_cnt++;
    end else begin
      acc_cnt       = 0;
      bus.ram_ready = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.ihit, bus.dhit, bus.imemload, bus.dmemload, bus.ram_ren, bus.ram_wen,
             bus.ram_addr, bus.ram_store, bus.halted, bus.timeout_err};
  endfunction

  task automatic wait_hit(output int n);
    n = 1;
    while (!(bus.ihit || bus.dhit) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store (store wins).
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdat,
                        input int dly, input logic [31:0] exp_addr, input logic [31:0] exp_load,
                        input string nm);
    int n;
    logic wr;
    logic tmo;
    int exp_lat;
    wr      = (kind >= 2);
    tmo     = (dly > TIMEOUT - 1);
    exp_lat = (tmo ? TIMEOUT - 1 : dly) + 2;
    @(negedge clk);
    bus.imemREN   = (kind == 0);
    bus.dmemREN   = (kind == 1) || (kind == 3);
    bus.dmemWEN   = (kind >= 2);
    bus.imemaddr  = (kind == 0) ? addr : ~addr;
    bus.dmemaddr  = (kind == 0) ? ~addr : addr;
    bus.dmemstore = wdat;
    ram_delay     = dly;
    @(negedge clk);
    chk({nm, "_ram_addr"}, bus.ram_addr, exp_addr);
    chk1({nm, "_ram_ren"}, bus.ram_ren, !wr);
    chk1({nm, "_ram_wen"}, bus.ram_wen, wr);
    if (wr) chk({nm, "_ram_store"}, bus.ram_store, wdat);
    wait_hit(n);
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_hit_side"}, {30'b0, bus.ihit, bus.dhit}, (kind == 0) ? 32'd2 : 32'd1);
    bus.imemREN = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    if (kind == 0) begin
      ref_iload = exp_load;
      chk({nm, "_imemload"}, bus.imemload, ref_iload);
    end else begin
      ref_dload = exp_load;
      chk({nm, "_dmemload"}, bus.dmemload, ref_dload);
    end
    if (wr && !tmo) ref_mem[exp_addr] = wdat;
    if (tmo) ref_terr = 1'b1;
    chk1({nm, "_timeout_err"}, bus.timeout_err, ref_terr);
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdat;
    int          dly;
    logic [31:0] exp_addr;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int bad;

    vecs[0] = '{0, 32'h4,   32'h0,        2,  32'h4,   32'h2002000A};
    vecs[1] = '{2, 32'h103, 32'hDEADBEEF, 1,  32'h100, 32'h0};
    vecs[2] = '{1, 32'h101, 32'h0,        0,  32'h100, 32'hDEADBEEF};
    vecs[3] = '{3, 32'h22,  32'h12345678, 3,  32'h20,  32'hDEADBEEF};
    vecs[4] = '{0, 32'h23,  32'h0,        0,  32'h20,  32'h12345678};
    vecs[5] = '{1, 32'h48,  32'h0,        15, 32'h48,  32'h0048FFB7};

    ram_mem[32'h4] = 32'h2002000A;
    ref_mem[32'h4] = 32'h2002000A;

    rst           = 1'b1;
    bus.halt      = 1'b0;
    bus.imemREN   = 1'b0;
    bus.imemaddr  = 32'h0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = 32'h0;
    bus.dmemstore = 32'h0;
    bus.ram_load  = 32'h0;
    bus.ram_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk1("reset_outputs_zero", any_out(), 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      access(vecs[i].kind, vecs[i].addr, vecs[i].wdat, vecs[i].dly,
             vecs[i].exp_addr, vecs[i].exp_load, $sformatf("vec%0d", i));
    end

    // Collision: data first, one IDLE cycle, then the fetch.
    @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h44;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h80;
    ram_delay    = 1;
    @(negedge clk);
    chk("col_first_addr", bus.ram_addr, 32'h80);
    chk1("col_first_ren", bus.ram_ren, 1'b1);
    wait_hit(n);
    chk("col_first_side", {30'b0, bus.ihit, bus.dhit}, 32'd1);
    chk("col_first_lat", 32'(n), 32'd3);
    ref_dload = ref_read(32'h80);
    chk("col_dmemload", bus.dmemload, ref_dload);
    bus.dmemREN = 1'b0;
    @(negedge clk);
    chk1("col_idle_gap", bus.ram_ren | bus.ihit | bus.dhit, 1'b0);
    @(negedge clk);
    chk("col_second_addr", bus.ram_addr, 32'h44);
    chk1("col_second_ren", bus.ram_ren, 1'b1);
    wait_hit(n);
    chk("col_second_side", {30'b0, bus.ihit, bus.dhit}, 32'd2);
    chk("col_second_lat", 32'(n), 32'd3);
    ref_iload = ref_read(32'h44);
    chk("col_imemload", bus.imemload, ref_iload);
    bus.imemREN = 1'b0;

    // Timeout: RAM never answers.
    access(1, 32'h300, 32'h0, 100, 32'h300, BAD_WORD, "timeout");

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      int          k;
      int          d;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] ea;
      logic [31:0] el;
      k  = int'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      w  = $urandom;
      d  = int'($urandom_range(0, 4));
      if (k < 2 && $urandom_range(0, 7) == 0) d = 20;
      ea = {a[31:2], 2'b00};
      if (k >= 2)      el = ref_dload;
      else if (d > 15) el = BAD_WORD;
      else             el = ref_read(ea);
      access(k, a, w, d, ea, el, $sformatf("rnd%0d", i));
    end

    // Halt rising during a fetch: fetch completes, then HALTED refuses traffic.
    @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h8;
    ram_delay    = 3;
    @(negedge clk);
    chk1("halt_iacc_ren", bus.ram_ren, 1'b1);
    bus.halt = 1'b1;
    wait_hit(n);
    chk("halt_ihit_side", {30'b0, bus.ihit, bus.dhit}, 32'd2);
    chk("halt_ihit_lat", 32'(n), 32'd5);
    ref_iload = ref_read(32'h8);
    chk("halt_imemload", bus.imemload, ref_iload);
    bus.imemREN = 1'b0;
    @(negedge clk);
    chk1("halt_halted", bus.halted, 1'b1);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'hC;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ram_ren || bus.ram_wen || bus.ihit || bus.dhit || !bus.halted) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'd0);
    chk("halt_imemload_held", bus.imemload, ref_iload);

    // Reset out of HALTED.
    rst         = 1'b1;
    bus.halt    = 1'b0;
    bus.imemREN = 1'b0;
    @(negedge clk);
    chk1("rst_from_halted_zero", any_out(), 1'b0);
    rst       = 1'b0;
    ref_iload = 32'h0;
    ref_dload = 32'h0;
    ref_terr  = 1'b0;

    // Reset in the middle of a data access: no hit, clean restart.
    @(negedge clk);
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h200;
    ram_delay    = 100;
    repeat (3) @(negedge clk);
    chk1("rstmid_ren_before", bus.ram_ren, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("rstmid_ren_after", bus.ram_ren, 1'b0);
    chk1("rstmid_outputs_zero", any_out(), 1'b0);
    rst         = 1'b0;
    bus.dmemREN = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.dhit || bus.ihit) bad++;
    end
    chk("rstmid_no_hit", 32'(bad), 32'd0);
    access(1, 32'h102, 32'h0, 1, 32'h100, ref_read(32'h100), "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
